// File: rtl/uart_tx_if.sv
// Purpose : host-side handshake and serial-line bundle for the UART transmitter.
// Signals : baud_rate [1:0] rate select (00=4800, 01=9600, 10=19200, 11=38400)
//           tx_data   [7:0] byte to send, sampled on accept
//           tx_start        send request, accepted when the transmitter is idle
//           tx              serial line, idle high
//           tx_busy         frame in progress
//           tx_done         one-cycle pulse at the end of the stop bit
// Modports: master = host side (drives request), slave = transmitter core.
interface uart_tx_if;
    logic [1:0] baud_rate;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output baud_rate,
        output tx_data,
        output tx_start,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  baud_rate,
        input  tx_data,
        input  tx_start,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_core.sv
// Purpose : 8N1 UART serial transmitter with its own baud generator.
//           A byte is accepted on tx_start while idle and shifted out LSB first
//           framed by a start bit (0) and a stop bit (1).
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous reset, active-high
//           bus  - uart_tx_if.slave (baud_rate, tx_data, tx_start in;
//                  tx, tx_busy, tx_done out, all registered)
// Params  : CLK_FREQ   - system clock frequency in Hz
//           DIV_W      - width of the baud divisor / counter
//           PARITY_ODD - parity sense when parity is enabled (0 even, 1 odd)
// Config  : define UART_TX_PARITY_EN to insert a parity bit after the data
//           bits (11-bit frame). Undefined: plain 8N1, 10-bit frame.
module uart_tx_core #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int unsigned DIV_4800  = CLK_FREQ / 32'd4800;
    localparam int unsigned DIV_9600  = CLK_FREQ / 32'd9600;
    localparam int unsigned DIV_19200 = CLK_FREQ / 32'd19200;
    localparam int unsigned DIV_38400 = CLK_FREQ / 32'd38400;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_baud_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [DATA_W-1:0]   r_shreg;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [DIV_W-1:0]    w_baud_cnt_nxt;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [DATA_W-1:0]   w_shreg_nxt;
    logic [IDX_W-1:0]    w_bit_idx_nxt;
    logic                w_tx_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [DIV_W-1:0]    w_div_sel;
    logic                w_bit_tick;

`ifdef UART_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`else
    logic                w_unused_parity_odd;
    assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

    // Divisor for the requested rate; only captured on accept.
    always_comb begin
        w_div_sel = DIV_W'(DIV_9600);
        case (bus.baud_rate)
            2'b00:   w_div_sel = DIV_W'(DIV_4800);
            2'b01:   w_div_sel = DIV_W'(DIV_9600);
            2'b10:   w_div_sel = DIV_W'(DIV_19200);
            default: w_div_sel = DIV_W'(DIV_38400);
        endcase
    end

    // End of the current bit period.
    assign w_bit_tick = (r_baud_cnt == (r_div - DIV_W'(1)));

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_div_nxt      = r_div;
        w_shreg_nxt    = r_shreg;
        w_bit_idx_nxt  = r_bit_idx;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        // Baud counter free-runs 0..DIV-1 only while a frame is active.
        if (r_state != S_IDLE) begin
            w_baud_cnt_nxt = w_bit_tick ? '0 : r_baud_cnt + DIV_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt       = 1'b1;
                w_busy_nxt     = 1'b0;
                w_baud_cnt_nxt = '0;
                if (bus.tx_start) begin
                    // Accept: capture byte and rate, start bit begins next cycle.
                    w_state_nxt    = S_START;
                    w_div_nxt      = w_div_sel;
                    w_shreg_nxt    = bus.tx_data;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_baud_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt   = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end

            S_START: begin
                if (w_bit_tick) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shreg[0];
                end
            end

            S_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        // Line shows shreg[0]; next bit is shreg[1] before the shift.
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                        w_shreg_nxt   = {1'b0, r_shreg[DATA_W-1:1]};
                        w_tx_nxt      = r_shreg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_tick) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_tx_nxt       = 1'b1;
                w_busy_nxt     = 1'b0;
                w_baud_cnt_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_div      <= '0;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_div      <= w_div_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    assign bus.tx      = r_tx;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;

endmodule
